// File: rtl/bbox_crop_scaler.sv
// rtl/bbox_crop_scaler.sv - nearest-neighbour crop of a bounding box into a fixed OUT_W x OUT_H tile
module bbox_crop_scaler #(
  parameter int WIDTH  = 100,
  parameter int HEIGHT = 100,
  parameter int OUT_W  = 16,
  parameter int OUT_H  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        rdy,
  input  logic [10:0] xMin,
  input  logic [10:0] xMax,
  input  logic [10:0] yMin,
  input  logic [10:0] yMax,
  output logic [23:0] addr,
  input  logic [7:0]  rddata,
  output logic [15:0] wraddr,
  output logic [7:0]  wrdata,
  output logic        wren,
  output logic        done,
  output logic        err
);

  localparam int LW   = $clog2(OUT_W);
  localparam int LH   = $clog2(OUT_H);
  localparam int PW_X = LW + 12;
  localparam int PW_Y = LH + 12;
  localparam logic [11:0] LP_WIDTH  = 12'(WIDTH);
  localparam logic [11:0] LP_HEIGHT = 12'(HEIGHT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADDR  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [10:0]     r_xmin;
  logic [10:0]     r_ymin;
  logic [11:0]     r_bw;
  logic [11:0]     r_bh;
  logic [LW-1:0]   r_ox;
  logic [LH-1:0]   r_oy;
  logic [23:0]     r_addr;
  logic            r_err;

  logic            w_valid;
  logic [11:0]     w_bw_in;
  logic [11:0]     w_bh_in;
  logic            w_last_oy;
  logic            w_last;
  logic [LW-1:0]   w_ox_nxt;
  logic [LH-1:0]   w_oy_nxt;
  logic [LW-1:0]   w_ox_map;
  logic [LH-1:0]   w_oy_map;
  logic [10:0]     w_x0;
  logic [10:0]     w_y0;
  logic [PW_X-1:0] w_prod_x;
  logic [PW_Y-1:0] w_prod_y;
  logic [11:0]     w_sx;
  logic [11:0]     w_sy;
  logic [23:0]     w_addr_nxt;

  // Request check: box must be ordered and lie inside the source image.
  always_comb begin
    w_valid = (xMin <= xMax) && (yMin <= yMax) &&
              ({1'b0, xMax} < LP_WIDTH) && ({1'b0, yMax} < LP_HEIGHT);
    w_bw_in = {1'b0, xMax} - {1'b0, xMin} + 12'd1;
    w_bh_in = {1'b0, yMax} - {1'b0, yMin} + 12'd1;
  end

  // Tile cursor advance (column-major) and source sample address for the next ADDR cycle.
  always_comb begin
    w_last_oy = (r_oy == {LH{1'b1}});
    w_last    = w_last_oy && (r_ox == {LW{1'b1}});
    w_oy_nxt  = r_oy + LH'(1);
    w_ox_nxt  = w_last_oy ? (r_ox + LW'(1)) : r_ox;
    // In IDLE the first sample is (0,0), so the address reduces to the box corner.
    if (r_state == S_IDLE) begin
      w_x0     = xMin;
      w_y0     = yMin;
      w_ox_map = '0;
      w_oy_map = '0;
    end else begin
      w_x0     = r_xmin;
      w_y0     = r_ymin;
      w_ox_map = w_ox_nxt;
      w_oy_map = w_oy_nxt;
    end
    // Full-width products: ox*bw < OUT_W*bw, so the shifted quotient stays below bw.
    w_prod_x   = PW_X'(w_ox_map) * PW_X'(r_bw);
    w_prod_y   = PW_Y'(w_oy_map) * PW_Y'(r_bh);
    w_sx       = 12'(w_x0) + 12'(w_prod_x >> LW);
    w_sy       = 12'(w_y0) + 12'(w_prod_y >> LH);
    w_addr_nxt = 24'(w_sx) * 24'(HEIGHT) + 24'(w_sy);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and per-state strobes.
  always_comb begin
    w_state_nxt = r_state;
    rdy         = 1'b0;
    wren        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        rdy = 1'b1;
        if (en && w_valid) begin
          w_state_nxt = S_ADDR;
        end
      end
      S_ADDR: begin
        w_state_nxt = S_WRITE;
      end
      S_WRITE: begin
        wren        = 1'b1;
        w_state_nxt = w_last ? S_DONE : S_ADDR;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Box latch, error flag, tile cursor and registered source address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_xmin <= '0;
      r_ymin <= '0;
      r_bw   <= '0;
      r_bh   <= '0;
      r_ox   <= '0;
      r_oy   <= '0;
      r_addr <= '0;
      r_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (en) begin
            r_xmin <= xMin;
            r_ymin <= yMin;
            r_bw   <= w_bw_in;
            r_bh   <= w_bh_in;
            if (w_valid) begin
              r_err  <= 1'b0;
              r_ox   <= '0;
              r_oy   <= '0;
              r_addr <= w_addr_nxt;
            end else begin
              r_err  <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          r_ox <= w_ox_nxt;
          r_oy <= w_oy_nxt;
          // Keep the final sample address on display through DONE and IDLE.
          if (!w_last) begin
            r_addr <= w_addr_nxt;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign addr   = r_addr;
  assign err    = r_err;
  assign wrdata = rddata;
  assign wraddr = 16'({r_ox, r_oy});

endmodule
